// File: rtl/adain_arith_pkg.sv
// Shared arithmetic definitions for the AdaIN statistics accumulator:
// operation codes, FSM state encoding and signed range helpers.
package adain_arith_pkg;

  localparam logic [1:0] MODE_SUM   = 2'b00;
  localparam logic [1:0] MODE_SUMSQ = 2'b01;
  localparam logic [1:0] MODE_SUB   = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;  // decoded as SUM

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Largest signed value representable in 'width' bits (width <= 64).
  function automatic logic [63:0] signed_max(input int unsigned width);
    signed_max = (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Smallest signed value in 'width' bits; callers truncate to 'width'.
  function automatic logic [63:0] signed_min(input int unsigned width);
    signed_min = ~signed_max(width);
  endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulator lane: selects x or x*x, adds or subtracts it, detects
// signed overflow in one extra bit, optionally clamps, and keeps a sticky flag.
module acc_lane
  import adain_arith_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 48,
  parameter int SATURATE  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic [1:0]                  mode,
  input  logic signed [IN_WIDTH-1:0]  x,
  output logic signed [ACC_WIDTH-1:0] acc,
  output logic                        ovf
);

  localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(signed_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(signed_min(ACC_WIDTH));

  logic signed [2*IN_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  term;
  logic signed [ACC_WIDTH:0]    sum_ext;
  logic                         wrap_ovf;
  logic signed [ACC_WIDTH-1:0]  acc_next;

  // Term select, widened add/sub, overflow detect and optional clamp.
  always_comb begin
    prod = x * x;
    if (mode == MODE_SUMSQ) begin
      term = ACC_WIDTH'(prod);
    end else begin
      term = ACC_WIDTH'(x);
    end
    if (mode == MODE_SUB) begin
      sum_ext = (ACC_WIDTH+1)'(acc) - (ACC_WIDTH+1)'(term);
    end else begin
      sum_ext = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(term);
    end
    // Top two bits disagree when the true result leaves the ACC_WIDTH range.
    wrap_ovf = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
    acc_next = sum_ext[ACC_WIDTH-1:0];
    if (wrap_ovf && (SATURATE != 0)) begin
      acc_next = sum_ext[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  // Accumulator and sticky overflow register; clr starts a new transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= acc_next;
      if (wrap_ovf) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_channel_accumulator.sv
// Multi-channel sequential accumulator: FSM, beat counter and handshakes,
// with one acc_lane per channel.
module seq_channel_accumulator
  import adain_arith_pkg::*;
#(
  parameter int IN_WIDTH    = 16,
  parameter int ACC_WIDTH   = 48,
  parameter int CHANNELS    = 4,
  parameter int COUNT_WIDTH = 16,
  parameter int SATURATE    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic [COUNT_WIDTH-1:0]        num_samples,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*IN_WIDTH-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*ACC_WIDTH-1:0] out_data,
  output logic [COUNT_WIDTH-1:0]        out_count,
  output logic [CHANNELS-1:0]           overflow,
  output logic                          busy
);

  state_t                 state_reg, state_next;
  logic [1:0]             mode_reg;
  logic [COUNT_WIDTH-1:0] num_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   clr;
  logic                   accept;
  logic                   last_beat;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state_reg;
    clr        = 1'b0;
    accept     = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    last_beat  = (count_reg + COUNT_WIDTH'(1)) == num_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          clr        = 1'b1;
          state_next = (num_samples == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = in_valid;
        if (in_valid && last_beat) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Transaction parameters and accepted-beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg  <= '0;
      num_reg   <= '0;
      count_reg <= '0;
    end else if (clr) begin
      mode_reg  <= mode;
      num_reg   <= num_samples;
      count_reg <= '0;
    end else if (accept) begin
      count_reg <= count_reg + COUNT_WIDTH'(1);
    end
  end

  assign out_count = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      acc_lane #(
        .IN_WIDTH (IN_WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .SATURATE (SATURATE)
      ) u_lane (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (accept),
        .mode(mode_reg),
        .x   (in_data[gi*IN_WIDTH +: IN_WIDTH]),
        .acc (out_data[gi*ACC_WIDTH +: ACC_WIDTH]),
        .ovf (overflow[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_seq_channel_accumulator.sv
// Directed bench: a 48-bit saturating instance plus 32-bit saturating and
// wrapping instances, all driven by the same stimulus.
module tb_seq_channel_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] num_samples;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;

  logic         rdy_m, vld_m, busy_m;
  logic [191:0] od_m;
  logic [15:0]  cnt_m;
  logic [3:0]   ovf_m;
  logic         rdy_s, vld_s, busy_s;
  logic [127:0] od_s;
  logic [15:0]  cnt_s;
  logic [3:0]   ovf_s;
  logic         rdy_w, vld_w, busy_w;
  logic [127:0] od_w;
  logic [15:0]  cnt_w;
  logic [3:0]   ovf_w;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  seq_channel_accumulator #(.ACC_WIDTH(48), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(rdy_m), .in_data(in_data), .out_valid(vld_m),
    .out_ready(out_ready), .out_data(od_m), .out_count(cnt_m), .overflow(ovf_m),
    .busy(busy_m));

  seq_channel_accumulator #(.ACC_WIDTH(32), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data), .out_valid(vld_s),
    .out_ready(out_ready), .out_data(od_s), .out_count(cnt_s), .overflow(ovf_s),
    .busy(busy_s));

  seq_channel_accumulator #(.ACC_WIDTH(32), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(rdy_w), .in_data(in_data), .out_valid(vld_w),
    .out_ready(out_ready), .out_data(od_w), .out_count(cnt_w), .overflow(ovf_w),
    .busy(busy_w));

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] lm(input int k);
    return 64'($signed(od_m[k*48 +: 48]));
  endfunction

  function automatic logic signed [63:0] ls(input int k);
    return 64'($signed(od_s[k*32 +: 32]));
  endfunction

  function automatic logic signed [63:0] lw(input int k);
    return 64'($signed(od_w[k*32 +: 32]));
  endfunction

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic go_start(input int m, input int n);
    start       = 1'b1;
    mode        = 2'(m);
    num_samples = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 64'hDEAD_BEEF_0BAD_F00D;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("consume_out_valid", 64'(vld_m), 0);
    chk("consume_busy", 64'(busy_m), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; num_samples = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(rdy_m), 0);
    chk("rst_out_valid", 64'(vld_m), 0);
    chk("rst_busy", 64'(busy_m), 0);
    chk("rst_out_count", 64'(cnt_m), 0);
    chk("rst_overflow", 64'(ovf_m), 0);
    chk("rst_lane0", lm(0), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(rdy_m), 0);
    $display("txn reset done");

    // SUM, N=4
    go_start(0, 4);
    chk("sum_busy", 64'(busy_m), 1);
    chk("sum_in_ready", 64'(rdy_m), 1);
    for (int i = 1; i <= 4; i++) begin
      beat(pack4(i, -5, 1000 * i, 0));
      if (i == 3) chk("sum_not_done_yet", 64'(vld_m), 0);
    end
    chk("sum_out_valid", 64'(vld_m), 1);
    chk("sum_in_ready_done", 64'(rdy_m), 0);
    chk("sum_lane0", lm(0), 10);
    chk("sum_lane1", lm(1), -20);
    chk("sum_lane2", lm(2), 10000);
    chk("sum_lane3", lm(3), 0);
    chk("sum_count", 64'(cnt_m), 4);
    chk("sum_overflow", 64'(ovf_m), 0);
    $display("txn SUM N=4 lane0=%0d lane1=%0d count=%0d", lm(0), lm(1), cnt_m);
    consume();

    // SUMSQ, N=3, with in_valid gaps carrying junk data
    go_start(1, 3);
    beat(pack4(-3, 0, -32768, 1));
    in_data = pack4(1000, 1000, 1000, 1000);
    repeat (2) begin
      @(posedge clk); #1;
      chk("sq_stall_in_ready", 64'(rdy_m), 1);
      chk("sq_stall_out_valid", 64'(vld_m), 0);
      chk("sq_stall_count", 64'(cnt_m), 1);
    end
    beat(pack4(4, 0, -32768, 1));
    @(posedge clk); #1;
    beat(pack4(32767, 0, -32768, 1));
    chk("sq_out_valid", 64'(vld_m), 1);
    chk("sq_lane0", lm(0), 64'sd1073676314);
    chk("sq_lane1", lm(1), 0);
    chk("sq_lane2", lm(2), 64'sd3221225472);
    chk("sq_lane3", lm(3), 3);
    chk("sq_count", 64'(cnt_m), 3);
    chk("sq_overflow", 64'(ovf_m), 0);
    $display("txn SUMSQ N=3 lane0=%0d lane2=%0d", lm(0), lm(2));
    consume();

    // SUB, N=2, then hold the result under backpressure with start asserted
    go_start(2, 2);
    beat(pack4(5, -7, 0, 0));
    beat(pack4(3, -7, 0, 0));
    chk("sub_lane0", lm(0), -8);
    chk("sub_lane1", lm(1), 14);
    start = 1'b1; mode = 2'b00; num_samples = 16'd1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(vld_m), 1);
      chk("bp_in_ready", 64'(rdy_m), 0);
      chk("bp_lane0_stable", lm(0), -8);
      chk("bp_count_stable", 64'(cnt_m), 2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0;
    chk("bp_release_out_valid", 64'(vld_m), 0);
    chk("bp_release_busy", 64'(busy_m), 0);
    @(posedge clk); #1;
    chk("bp_still_idle", 64'(busy_m), 0);
    $display("txn SUB N=2 backpressure lane0=%0d", lm(0));

    // Reserved mode behaves as SUM
    go_start(3, 1);
    beat(pack4(9, -9, 0, 0));
    chk("rsvd_lane0", lm(0), 9);
    chk("rsvd_lane1", lm(1), -9);
    $display("txn RSVD N=1 lane0=%0d", lm(0));
    consume();

    // N=0 completes immediately with zero results
    go_start(0, 0);
    chk("n0_out_valid", 64'(vld_m), 1);
    chk("n0_in_ready", 64'(rdy_m), 0);
    chk("n0_count", 64'(cnt_m), 0);
    chk("n0_lane0", lm(0), 0);
    chk("n0_lane1", lm(1), 0);
    $display("txn N=0 count=%0d", cnt_m);
    consume();

    // SUMSQ of -32768 four times: overflows a 32-bit accumulator
    go_start(1, 4);
    repeat (4) beat(pack4(-32768, -32768, -32768, -32768));
    chk("sat_out_valid", 64'(vld_s), 1);
    chk("sat_in_ready", 64'(rdy_s), 0);
    chk("sat_count", 64'(cnt_s), 4);
    chk("sat_busy", 64'(busy_s), 1);
    chk("wrap_out_valid", 64'(vld_w), 1);
    chk("wrap_in_ready", 64'(rdy_w), 0);
    chk("wrap_count", 64'(cnt_w), 4);
    chk("wrap_busy", 64'(busy_w), 1);
    for (int k = 0; k < 4; k++) begin
      chk("sat_lane", ls(k), 64'sd2147483647);
      chk("wrap_lane", lw(k), 0);
      chk("wide_lane", lm(k), 64'sd4294967296);
    end
    chk("sat_overflow", 64'(ovf_s), 4'b1111);
    chk("wrap_overflow", 64'(ovf_w), 4'b1111);
    chk("wide_overflow", 64'(ovf_m), 0);
    $display("txn SAT N=4 sat=%0d wrap=%0d wide=%0d", ls(0), lw(0), lm(0));
    consume();

    // Asynchronous reset in the middle of ACCUM, then a fresh transaction
    go_start(0, 4);
    chk("ar_overflow_cleared", 64'(ovf_s), 0);
    beat(pack4(7, 7, 7, 7));
    beat(pack4(7, 7, 7, 7));
    chk("ar_count_before", 64'(cnt_m), 2);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", 64'(busy_m), 0);
    chk("ar_in_ready", 64'(rdy_m), 0);
    chk("ar_out_valid", 64'(vld_m), 0);
    chk("ar_count", 64'(cnt_m), 0);
    chk("ar_lane0", lm(0), 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    go_start(0, 2);
    beat(pack4(7, 7, 7, 7));
    beat(pack4(7, 7, 7, 7));
    chk("ar_fresh_out_valid", 64'(vld_m), 1);
    chk("ar_fresh_lane0", lm(0), 14);
    chk("ar_fresh_count", 64'(cnt_m), 2);
    $display("txn RESET-ABORT then SUM N=2 lane0=%0d", lm(0));
    consume();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
